ntt_stage_sequencer: RTL and testbench
======================================

// Module: ntt_stage_sequencer
// PURPOSE
//  Top-level stage controller for the 257-point NTT memory path. Sits directly
//  upstream of the memory controller and drives its stage, incr and soft_reset
//  inputs. Runs NUM_STAGES passes of STEPS_PER_STAGE address steps, throttled by
//  datapath ready, with a pipeline drain between passes. Reports busy/done.
// PARAMETERS
//  NUM_STAGES       3   passes per transform; stage 0 is mode 0, stages >=1 are mode 1
//  STEPS_PER_STAGE  85  incr pulses per pass (equals address-generator depth)
//  DRAIN_CYCLES     4   idle cycles after last incr of a pass (datapath latency), >=1
// PORTS
//  clk          in   1   clock, all state on rising edge
//  reset        in   1   asynchronous, active-low reset
//  start        in   1   request a full transform; sampled only in IDLE
//  abort        in   1   cancel current transform; sampled in every state
//  ready        in   1   datapath can accept one address step this cycle
//  stage        out  2   current pass index, to memory controller
//  incr         out  1   advance address/shift/we state this cycle
//  soft_reset   out  1   restart memory-controller counters this cycle
//  step         out  7   steps completed in current pass, 0..STEPS_PER_STAGE-1
//  busy         out  1   high in every state except IDLE
//  done         out  1   one-cycle pulse when the final pass has drained
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, stage=0, step=0, drain counter=0;
//   outputs incr=0, soft_reset=0, busy=0, done=0.
//  States: IDLE, CLEAR, RUN, DRAIN, DONE (registered, binary).
//  IDLE : start=1 & abort=0 -> CLEAR, stage<=0. Otherwise stay.
//  CLEAR: soft_reset=1 for exactly this cycle; step<=0; always -> RUN.
//  RUN  : incr = ready & ~abort (combinational from state and ready).
//   On incr: step<=step+1. On incr with step==STEPS_PER_STAGE-1: step<=0,
//   drain counter<=0, -> DRAIN. ready=0 holds all state (stall, no timeout).
//  DRAIN: incr=0; counter increments each cycle; on counter==DRAIN_CYCLES-1:
//   if stage==NUM_STAGES-1 -> DONE, else stage<=stage+1 and -> CLEAR.
//  DONE : done=1 for this cycle only; stage<=0; -> IDLE. busy still 1 here.
//  abort (state!=IDLE): highest priority; soft_reset=1 and incr=0 in the
//   sampling cycle; next state IDLE, stage=0, step=0, counters=0; no done pulse.
//  abort & start together in IDLE: abort wins, remain IDLE, soft_reset=0.
//  start outside IDLE ignored (no queuing).
//  Latency with ready tied high: per pass 1 CLEAR + STEPS_PER_STAGE RUN +
//   DRAIN_CYCLES; start sampled at edge 0 -> done high in cycle
//   1 + NUM_STAGES*(1+STEPS_PER_STAGE+DRAIN_CYCLES) = 271 with defaults.
//  stage is registered and changes only on CLEAR entry or return to IDLE;
//   it is stable throughout RUN, so mode never changes between incr pulses.
//  Exactly STEPS_PER_STAGE incr pulses per pass; soft_reset and incr never
//   high in the same cycle.
//  Async reset mid-transform: immediate return to reset values, no done.
// TESTING
//  1 ready=1, pulse start -> soft_reset at cycles 1,91,181; 85 incr each pass;
//    stage 0/1/2; done=1 only in cycle 271; busy high cycles 1..271.
//  2 ready toggles 1,0 every cycle -> still 85 incr/pass; RUN length 170 cycles;
//    stage constant during RUN; done once.
//  3 abort in RUN of stage 1 at step 40 -> that cycle incr=0, soft_reset=1;
//    next cycle IDLE, stage=0, step=0, busy=0; done never asserted.
//  4 start held high through whole run -> after DONE, new transform begins
//    (CLEAR in cycle 273); start pulses during busy cause no restart.
//  5 start and abort same cycle in IDLE -> stays IDLE, all outputs 0.
//  6 reset low for 1 cycle during DRAIN of stage 2 -> outputs go to reset
//    values asynchronously; no done; a later start runs full 271-cycle sequence.

Source files
------------

// File: rtl/ntt_stage_sequencer_if.sv
// Handshake bundle between the host/datapath side and the NTT stage sequencer.
// The slave modport is the sequencer; the master drives start/abort/ready.
interface ntt_stage_sequencer_if;
  logic       start;
  logic       abort;
  logic       ready;
  logic [1:0] stage;
  logic       incr;
  logic       soft_reset;
  logic [6:0] step;
  logic       busy;
  logic       done;

  modport master (
    output start, abort, ready,
    input  stage, incr, soft_reset, step, busy, done
  );

  modport slave (
    input  start, abort, ready,
    output stage, incr, soft_reset, step, busy, done
  );
endinterface

// File: rtl/ntt_stage_sequencer.sv
// Stage controller for the 257-point NTT memory path: runs NUM_STAGES passes of
// STEPS_PER_STAGE ready-throttled address steps, draining the datapath between passes.
module ntt_stage_sequencer #(
  parameter int NUM_STAGES      = 3,
  parameter int STEPS_PER_STAGE = 85,
  parameter int DRAIN_CYCLES    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  ntt_stage_sequencer_if.slave  bus
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [6:0]    LAST_STEP  = 7'(STEPS_PER_STAGE - 1);
  localparam logic [1:0]    LAST_STAGE = 2'(NUM_STAGES - 1);
  localparam logic [DW-1:0] LAST_DRAIN = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    stage_q, stage_d;
  logic [6:0]    step_q,  step_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          incr_d, soft_reset_d, done_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      step_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      step_q  <= step_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    stage_d      = stage_q;
    step_d       = step_q;
    drain_d      = drain_q;
    incr_d       = 1'b0;
    soft_reset_d = 1'b0;
    done_d       = 1'b0;

    // Abort overrides every busy state and also restarts the memory controller.
    if (state_q != S_IDLE && bus.abort) begin
      state_d      = S_IDLE;
      stage_d      = '0;
      step_d       = '0;
      drain_d      = '0;
      soft_reset_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start && !bus.abort) begin
            state_d = S_CLEAR;
            stage_d = '0;
          end
        end
        S_CLEAR: begin
          soft_reset_d = 1'b1;
          step_d       = '0;
          state_d      = S_RUN;
        end
        S_RUN: begin
          if (bus.ready) begin
            incr_d = 1'b1;
            if (step_q == LAST_STEP) begin
              step_d  = '0;
              drain_d = '0;
              state_d = S_DRAIN;
            end else begin
              step_d = step_q + 7'd1;
            end
          end
        end
        S_DRAIN: begin
          drain_d = drain_q + 1'b1;
          if (drain_q == LAST_DRAIN) begin
            drain_d = '0;
            if (stage_q == LAST_STAGE) begin
              state_d = S_DONE;
            end else begin
              stage_d = stage_q + 2'd1;
              state_d = S_CLEAR;
            end
          end
        end
        S_DONE: begin
          done_d  = 1'b1;
          stage_d = '0;
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          stage_d = '0;
          step_d  = '0;
          drain_d = '0;
        end
      endcase
    end
  end

  assign bus.incr       = incr_d;
  assign bus.soft_reset = soft_reset_d;
  assign bus.done       = done_d;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.stage      = stage_q;
  assign bus.step       = step_q;

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Scoreboard bench for ntt_stage_sequencer: stimulus queues expected soft_reset/done
// events (cycle, stage, incr count since previous event); a monitor pops and checks them.
module tb_ntt_stage_sequencer;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  ntt_stage_sequencer_if bus ();

  ntt_stage_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int kind;   // 0 = soft_reset, 1 = done
    int cyc;
    int stage;
    int nincr;
  } ev_t;

  ev_t exp_q[$];
  int  base         = 0;
  bit  ready_toggle = 1'b0;
  int  incr_cnt     = 0;
  int  run_stage    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cyc=%0d)", name, act, exp, cyc);
    end
  endtask

  task automatic at_cyc(input int k);
    while (cyc < base + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int kind, input int k, input int st, input int n);
    ev_t e;
    e.kind  = kind;
    e.cyc   = base + k;
    e.stage = st;
    e.nincr = n;
    exp_q.push_back(e);
  endtask

  task automatic push_full_run();
    push(0, 1,   0, 0);
    push(0, 91,  1, 85);
    push(0, 181, 2, 85);
    push(1, 271, 2, 85);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    at_cyc(1);
    bus.start = 1'b0;
  endtask

  // ready driver: free-running toggle relative to the transform start cycle
  initial begin
    bus.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.ready = ready_toggle ? (((cyc - base) % 2) == 1) : 1'b1;
    end
  end

  // Monitor: counts incr pulses and checks each soft_reset/done against the scoreboard.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        incr_cnt = 0;
      end else begin
        if (bus.incr) begin
          chk("run_stage", {30'd0, bus.stage}, run_stage);
          incr_cnt++;
        end
        if (bus.soft_reset || bus.done) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got soft_reset=%0b done=%0b at cyc=%0d required none",
                     bus.soft_reset, bus.done, cyc);
          end else begin
            e = exp_q.pop_front();
            chk("ev_kind", bus.done ? 32'd1 : 32'd0, e.kind);
            chk("ev_cycle", cyc, e.cyc);
            chk("ev_stage", {30'd0, bus.stage}, e.stage);
            chk("ev_incr_count", incr_cnt, e.nincr);
            chk("ev_busy", {31'd0, bus.busy}, 1);
            chk("ev_no_incr", {31'd0, bus.incr}, 0);
            run_stage = e.stage;
            $display("event %s cyc=%0d stage=%0d incr_prev=%0d",
                     bus.done ? "done" : "soft_reset", cyc - base, bus.stage, incr_cnt);
          end
          incr_cnt = 0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    reset     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  {31'd0, bus.busy}, 0);
    chk("rst_incr",  {31'd0, bus.incr}, 0);
    chk("rst_sreset",{31'd0, bus.soft_reset}, 0);
    chk("rst_done",  {31'd0, bus.done}, 0);
    chk("rst_stage", {30'd0, bus.stage}, 0);
    chk("rst_step",  {25'd0, bus.step}, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // 1: ready tied high, full transform
    base = cyc;
    push_full_run();
    pulse_start();
    @(negedge clk);
    chk("t1_busy_c1", {31'd0, bus.busy}, 1);
    at_cyc(271);
    @(negedge clk);
    chk("t1_busy_c271", {31'd0, bus.busy}, 1);
    at_cyc(272);
    @(negedge clk);
    chk("t1_busy_c272", {31'd0, bus.busy}, 0);
    chk("t1_stage_c272", {30'd0, bus.stage}, 0);
    at_cyc(280);
    chk("t1_sb_empty", exp_q.size(), 0);
    $display("transaction t1 full run complete");

    // 2: ready alternating 0,1 from the first RUN cycle
    base = cyc;
    ready_toggle = 1'b1;
    push(0, 1,   0, 0);
    push(0, 176, 1, 85);
    push(0, 350, 2, 85);
    push(1, 524, 2, 85);
    pulse_start();
    at_cyc(530);
    ready_toggle = 1'b0;
    chk("t2_sb_empty", exp_q.size(), 0);
    $display("transaction t2 throttled run complete");

    // 3: abort in stage 1 at step 40
    base = cyc;
    push(0, 1,   0, 0);
    push(0, 91,  1, 85);
    push(0, 132, 1, 40);
    pulse_start();
    at_cyc(132);
    bus.abort = 1'b1;
    @(negedge clk);
    chk("t3_abort_step", {25'd0, bus.step}, 40);
    chk("t3_abort_incr", {31'd0, bus.incr}, 0);
    chk("t3_abort_sreset", {31'd0, bus.soft_reset}, 1);
    at_cyc(133);
    bus.abort = 1'b0;
    @(negedge clk);
    chk("t3_post_busy",  {31'd0, bus.busy}, 0);
    chk("t3_post_stage", {30'd0, bus.stage}, 0);
    chk("t3_post_step",  {25'd0, bus.step}, 0);
    at_cyc(300);
    chk("t3_sb_empty", exp_q.size(), 0);
    $display("transaction t3 abort complete");

    // 4: start held high restarts only after DONE, then abort the second run
    base = cyc;
    push_full_run();
    push(0, 273, 0, 0);
    push(0, 280, 0, 6);
    bus.start = 1'b1;
    at_cyc(275);
    bus.start = 1'b0;
    at_cyc(280);
    bus.abort = 1'b1;
    at_cyc(281);
    bus.abort = 1'b0;
    @(negedge clk);
    chk("t4_post_busy", {31'd0, bus.busy}, 0);
    at_cyc(290);
    chk("t4_sb_empty", exp_q.size(), 0);
    $display("transaction t4 held start complete");

    // 5: start and abort together in IDLE
    base = cyc;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    chk("t5_sreset_c0", {31'd0, bus.soft_reset}, 0);
    at_cyc(1);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    @(negedge clk);
    chk("t5_busy",   {31'd0, bus.busy}, 0);
    chk("t5_incr",   {31'd0, bus.incr}, 0);
    chk("t5_sreset", {31'd0, bus.soft_reset}, 0);
    chk("t5_done",   {31'd0, bus.done}, 0);
    chk("t5_stage",  {30'd0, bus.stage}, 0);
    chk("t5_step",   {25'd0, bus.step}, 0);
    at_cyc(10);
    chk("t5_sb_empty", exp_q.size(), 0);
    $display("transaction t5 start+abort complete");

    // 6: async reset during stage-2 drain, then a clean full run
    base = cyc;
    push(0, 1,   0, 0);
    push(0, 91,  1, 85);
    push(0, 181, 2, 85);
    pulse_start();
    at_cyc(268);
    reset = 1'b0;
    #1;
    chk("t6_rst_busy",   {31'd0, bus.busy}, 0);
    chk("t6_rst_stage",  {30'd0, bus.stage}, 0);
    chk("t6_rst_step",   {25'd0, bus.step}, 0);
    chk("t6_rst_done",   {31'd0, bus.done}, 0);
    chk("t6_rst_sreset", {31'd0, bus.soft_reset}, 0);
    at_cyc(269);
    reset = 1'b1;
    at_cyc(300);
    chk("t6_sb_empty_a", exp_q.size(), 0);
    base = cyc;
    push_full_run();
    pulse_start();
    at_cyc(272);
    @(negedge clk);
    chk("t6_busy_end", {31'd0, bus.busy}, 0);
    chk("t6_sb_empty_b", exp_q.size(), 0);
    $display("transaction t6 reset recovery complete");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
